// File: rtl/qarctan_prep.sv
// qarctan_prep: conjugate product of each I/Q sample with the previous one, then the
// qarctan numerator/denominator pair and {quad, ysign} side info for the divider.
module qarctan_prep #(
    parameter int BITS       = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         real_rd_en,
    input  logic                         real_empty,
    input  logic signed [DATA_WIDTH-1:0] real_dout,
    output logic                         imag_rd_en,
    input  logic                         imag_empty,
    input  logic signed [DATA_WIDTH-1:0] imag_dout,
    output logic                         a_wr_en,
    input  logic                         a_full,
    output logic signed [DATA_WIDTH-1:0] a_din,
    output logic                         b_wr_en,
    input  logic                         b_full,
    output logic signed [DATA_WIDTH-1:0] b_din,
    output logic                         s_wr_en,
    input  logic                         s_full,
    output logic [1:0]                   s_din
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic signed [PW-1:0] RND = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};

    typedef enum logic [1:0] {S_READ, S_MULT, S_COMB, S_WRITE} state_t;
    state_t r_state;

    logic signed [DATA_WIDTH-1:0] r_cur_r, r_cur_i, r_prev_r, r_prev_i, r_r, r_i;
    logic signed [PW-1:0]         w_pr, w_pi, w_pr_adj, w_pi_adj;
    logic signed [DATA_WIDTH-1:0] w_r, w_i, w_abs_y, w_num, w_den;

    assign w_pr = PW'(r_prev_r) * PW'(r_cur_r) + PW'(r_prev_i) * PW'(r_cur_i);
    assign w_pi = PW'(r_prev_r) * PW'(r_cur_i) - PW'(r_prev_i) * PW'(r_cur_r);
    // Biasing negatives before the arithmetic shift makes it truncate toward zero
    assign w_pr_adj = w_pr + (w_pr[PW-1] ? RND : '0);
    assign w_pi_adj = w_pi + (w_pi[PW-1] ? RND : '0);
    assign w_r = DATA_WIDTH'(w_pr_adj >>> BITS);
    assign w_i = DATA_WIDTH'(w_pi_adj >>> BITS);

    assign w_abs_y = (r_i[MSB] ? -r_i : r_i) + DATA_WIDTH'(1);
    assign w_num   = r_r[MSB] ? r_r + w_abs_y : r_r - w_abs_y;
    assign w_den   = r_r[MSB] ? w_abs_y - r_r : r_r + w_abs_y;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_READ;
            real_rd_en <= 1'b0;
            imag_rd_en <= 1'b0;
            a_wr_en    <= 1'b0;
            b_wr_en    <= 1'b0;
            s_wr_en    <= 1'b0;
            a_din      <= '0;
            b_din      <= '0;
            s_din      <= '0;
            r_cur_r    <= '0;
            r_cur_i    <= '0;
            r_prev_r   <= '0;
            r_prev_i   <= '0;
            r_r        <= '0;
            r_i        <= '0;
        end else begin
            real_rd_en <= 1'b0;
            imag_rd_en <= 1'b0;
            a_wr_en    <= 1'b0;
            b_wr_en    <= 1'b0;
            s_wr_en    <= 1'b0;
            case (r_state)
                S_READ: if (!real_empty && !imag_empty) begin
                    real_rd_en <= 1'b1;
                    imag_rd_en <= 1'b1;
                    r_cur_r    <= real_dout;
                    r_cur_i    <= imag_dout;
                    r_state    <= S_MULT;
                end
                S_MULT: begin
                    r_r      <= w_r;
                    r_i      <= w_i;
                    r_prev_r <= r_cur_r;
                    r_prev_i <= r_cur_i;
                    r_state  <= S_COMB;
                end
                S_COMB: begin
                    a_din   <= w_num << BITS;
                    b_din   <= w_den;
                    s_din   <= {r_r[MSB], r_i[MSB]};
                    r_state <= S_WRITE;
                end
                S_WRITE: if (!a_full && !b_full && !s_full) begin
                    a_wr_en <= 1'b1;
                    b_wr_en <= 1'b1;
                    s_wr_en <= 1'b1;
                    r_state <= S_READ;
                end
                default: r_state <= S_READ;
            endcase
        end
    end
endmodule

// File: doc/qarctan_prep.md
# qarctan_prep

Front half of the FM demodulator's quantized arctangent, directly upstream of `divide_two_inputs`. For each I/Q sample it forms the conjugate product with the previous sample, then the qarctan numerator/denominator pair. It writes the numerator to the divider's A FIFO, the denominator to its B FIFO, and a 2-bit side-info word to a third FIFO for the downstream angle stage. It is a 32-bit signed fixed-point block with BITS fractional bits.

## Interface
- BITS, 10, fractional bits of the fixed-point format
- DATA_WIDTH, 32, sample/result width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- real_rd_en  out  1  pop real FIFO
- real_empty  in  1  real FIFO empty
- real_dout  in  DATA_WIDTH  signed I sample
- imag_rd_en  out  1  pop imag FIFO
- imag_empty  in  1  imag FIFO empty
- imag_dout  in  DATA_WIDTH  signed Q sample
- a_wr_en  out  1  push numerator (divider A input)
- a_full  in  1  A FIFO full
- a_din  out  DATA_WIDTH  numerator, quantized: num << BITS
- b_wr_en  out  1  push denominator (divider B input)
- b_full  in  1  B FIFO full
- b_din  out  DATA_WIDTH  denominator, always >= 1
- s_wr_en  out  1  push side info
- s_full  in  1  side FIFO full
- s_din  out  2  {quad, ysign}: quad=1 when r<0; ysign=1 when i<0

## Operation
- FSM states: S_READ, S_MULT, S_COMB, S_WRITE.
- S_READ:
  - When both real_empty and imag_empty are 0, assert real_rd_en and imag_rd_en together for one cycle.
  - Latch cur_r and cur_i, then go to S_MULT.
  - Never pop only one of the two FIFOs.
- S_MULT computes the 2*DATA_WIDTH products:
  - pr = prev_r*cur_r + prev_i*cur_i
  - pi = prev_r*cur_i - prev_i*cur_r
- S_MULT then dequantizes: r = pr / 2^BITS and i = pi / 2^BITS.
  - Truncate toward zero: add 2^BITS-1 before the arithmetic shift when the value is negative.
  - Keep the low DATA_WIDTH bits.
- S_MULT then sets prev_r <= cur_r and prev_i <= cur_i, and goes to S_COMB.
- S_COMB forms the pair, with abs_y = |i| + 1:
  - If r >= 0: num = r - abs_y, den = r + abs_y, quad = 0.
  - Else: num = r + abs_y, den = abs_y - r, quad = 1.
  - Register a_din = num << BITS (wraps at DATA_WIDTH), b_din = den, s_din = {quad, i<0}.
- S_WRITE:
  - When a_full, b_full and s_full are all 0, assert a_wr_en, b_wr_en and s_wr_en together for one cycle, then go to S_READ.
  - Otherwise hold all outputs stable and wait.
  - Never write a subset of the three FIFOs.
- prev_r and prev_i reset to 0, so the first output uses a zero history.
- Arithmetic wrap on overflow is accepted; no saturation.

## Timing
- Reset is asynchronous, active-low. Reset values:
  - FSM = S_READ.
  - All rd_en and wr_en outputs = 0.
  - a_din, b_din, s_din = 0.
  - prev and cur registers = 0.
- Latency: pop in cycle N, write strobes in cycle N+3 if no output is full. Back-to-back throughput is one sample per 4 cycles.
- rd_en and wr_en are registered single-cycle pulses and are never asserted in the same cycle.
- Reset asserted mid-operation aborts the sample without completing the write. History clears to 0.
- An empty input stalls in S_READ with no pops.
- A full output on any FIFO stalls in S_WRITE with data held.
- An input becoming non-empty while stalled in S_WRITE has no effect until the write completes.

## Test plan
- Sample 1 = (1024,0) from reset (zero history) -> a=-1024, b=1, s=00.
- Sequence (1024,0) then (0,1024) -> second output a=-1049600, b=1025, s=00.
- Sequence (1024,0) then (-1024,0) -> second output a=-1047552, b=1025, s=10.
- Rounding: sequence (1,0) then (-1,0) -> product -1 truncates to r=0 -> a=-1024, b=1, s=00.
- Negative i: sequence (0,1024) then (1024,0) -> i=-1024 -> a=-1049600, b=1025, s=01.
- Backpressure: hold b_full=1 for 20 cycles with a_full=s_full=0:
  - No wr_en is asserted and no further pops occur; data stays stable.
  - After release, exactly one write of all three.
  - Random empty/full toggling over 256 samples matches the golden file with 0 errors.
- Pulse reset low during S_MULT -> all outputs are 0 on the next edge. The next sample behaves as the first sample after reset.
